sram_controller: RTL and testbench

Data-memory controller between the MEM stage and an off-chip 16-bit asynchronous SRAM. It serves one 32-bit word per request as two 16-bit half accesses, each stretched over a fixed number of wait-state cycles. While a request is in flight, `ready` is low; the top level ORs `!ready` into the pipeline freeze so that IF, ID, EXE and MEM hold their state. On completion it returns read data to the MEM/WB path.

---
 rtl/arm_pkg.sv | 15 +
 rtl/sram_controller.sv | 133 +++++++++++++
 tb/tb_sram_controller.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the data-memory path: SRAM controller states and
// default memory-map / timing constants.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } sram_state_t;

  localparam logic [31:0] DATA_BASE_ADDR   = 32'd1024;
  localparam int          SRAM_WAIT_STATES = 5;

endpackage

// File: rtl/sram_controller.sv
// Serves one 32-bit MEM-stage access as two wait-stated 16-bit accesses to an
// asynchronous SRAM; ready=0 freezes the pipeline until the DONE cycle.
module sram_controller
  import arm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DATA_BASE_ADDR,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_STATES = SRAM_WAIT_STATES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output sram_state_t        dbg_state
);

  localparam int            CW       = $clog2(WAIT_STATES);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_STATES - 1);

  sram_state_t        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               write_q, write_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [15:0]        wdata_hi_q, wdata_hi_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic               sram_we_n_q, sram_we_n_d;
  logic [15:0]        sram_dq_out_q, sram_dq_out_d;
  logic               sram_dq_oe_q, sram_dq_oe_d;

  logic        req;
  logic [31:0] offset;
  logic        unused_offset_bits;

  assign req    = rd_en | wr_en;
  assign offset = address - BASE_ADDR;
  // Byte lane and out-of-range word bits are dropped: addresses wrap silently.
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    write_d       = write_q;
    word_d        = word_q;
    wdata_hi_d    = wdata_hi_q;
    rdata_d       = rdata_q;
    sram_addr_d   = sram_addr_q;
    sram_we_n_d   = sram_we_n_q;
    sram_dq_out_d = sram_dq_out_q;
    sram_dq_oe_d  = sram_dq_oe_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d       = LOW;
          cnt_d         = CNT_LAST;
          write_d       = wr_en;
          word_d        = offset[SRAM_AW:2];
          wdata_hi_d    = wdata[31:16];
          sram_addr_d   = {offset[SRAM_AW:2], 1'b0};
          sram_dq_out_d = wdata[15:0];
          sram_dq_oe_d  = wr_en;
          sram_we_n_d   = ~wr_en;
        end
      end
      LOW, HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          // Strobe rises one cycle early so address and data are held past it.
          if (cnt_q == CW'(1)) sram_we_n_d = 1'b1;
        end else if (state_q == LOW) begin
          if (!write_q) rdata_d[15:0] = sram_dq_in;
          state_d       = HIGH;
          cnt_d         = CNT_LAST;
          sram_addr_d   = {word_q, 1'b1};
          sram_dq_out_d = wdata_hi_q;
          sram_we_n_d   = ~write_q;
        end else begin
          if (!write_q) rdata_d[31:16] = sram_dq_in;
          state_d      = DONE;
          sram_we_n_d  = 1'b1;
          sram_dq_oe_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      word_q        <= '0;
      wdata_hi_q    <= '0;
      rdata_q       <= '0;
      sram_addr_q   <= '0;
      sram_we_n_q   <= 1'b1;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      write_q       <= write_d;
      word_q        <= word_d;
      wdata_hi_q    <= wdata_hi_d;
      rdata_q       <= rdata_d;
      sram_addr_q   <= sram_addr_d;
      sram_we_n_q   <= sram_we_n_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
    end
  end

  assign ready       = (state_q == IDLE) ? ~req : (state_q == DONE);
  assign rdata       = rdata_q;
  assign sram_addr   = sram_addr_q;
  assign sram_we_n   = sram_we_n_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 16-bit SRAM model and
// a read-data expected queue.
module tb_sram_controller;
  import arm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  sram_state_t dbg_state;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  logic [15:0] mem [256];

  // access observations
  int          n_low;
  int          we_lo;
  int          we_hi;
  logic [17:0] addr_lo;
  logic [17:0] addr_hi;
  logic        got_done;

  sram_controller dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_we_n  (sram_we_n),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .dbg_state  (dbg_state)
  );

  // clock / SRAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) mem[sram_addr[7:0]] <= sram_dq_out;
  end
  assign sram_dq_in = mem[sram_addr[7:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Applies a request (now if chain, else just after the next rising edge)
  // and observes it until the DONE cycle, sampling on falling edges.
  task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] data, input bit chain);
    if (!chain) begin
      @(posedge clk);
      #1;
    end
    wr_en = wr;
    rd_en = rd;
    address = addr;
    wdata = data;
    n_low = 0;
    we_lo = 0;
    we_hi = 0;
    addr_lo = '1;
    addr_hi = '1;
    got_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin
        got_done = 1'b1;
        break;
      end
      n_low++;
      if (dbg_state == LOW) begin
        addr_lo = sram_addr;
        if (!sram_we_n) we_lo++;
      end
      if (dbg_state == HIGH) begin
        addr_hi = sram_addr;
        if (!sram_we_n) we_hi++;
      end
    end
    check("done_seen", 32'(got_done), 32'd1);
    check("done_state", 32'(dbg_state), 32'(DONE));
    if (!wr) begin
      if (exp_q.size() == 0) check("exp_q_empty", 32'd0, 32'd1);
      else check("rdata", rdata, exp_q.pop_front());
    end
  endtask

  task automatic release_req();
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    // reset
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;

    // 1: write 0xDEADBEEF at 1024
    run_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
    release_req();
    check("wr1_ready_low", 32'(n_low), 32'd11);
    check("wr1_we_lo", 32'(we_lo), 32'd4);
    check("wr1_we_hi", 32'(we_hi), 32'd4);
    check("wr1_mem0", 32'(mem[0]), 32'h0000BEEF);
    check("wr1_mem1", 32'(mem[1]), 32'h0000DEAD);
    check("wr1_done_oe", 32'(sram_dq_oe), 32'd0);
    check("wr1_done_we_n", 32'(sram_we_n), 32'd1);

    // 2: read it back
    exp_q.push_back(32'hDEADBEEF);
    run_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    release_req();
    check("rd1_ready_low", 32'(n_low), 32'd11);
    check("rd1_we_lo", 32'(we_lo), 32'd0);
    @(negedge clk);
    check("rd1_rdata_held", rdata, 32'hDEADBEEF);

    // 3: word at 1028, then read through byte address 1030
    run_access(1'b1, 1'b0, 32'd1028, 32'h12345678, 1'b0);
    release_req();
    check("wr2_addr_lo", 32'(addr_lo), 32'd2);
    check("wr2_addr_hi", 32'(addr_hi), 32'd3);
    exp_q.push_back(32'h12345678);
    run_access(1'b0, 1'b1, 32'd1030, 32'h0, 1'b0);
    release_req();
    check("rd2_addr_lo", 32'(addr_lo), 32'd2);
    check("rd2_addr_hi", 32'(addr_hi), 32'd3);

    // 4: read then write chained straight out of DONE
    exp_q.push_back(32'h12345678);
    run_access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    run_access(1'b1, 1'b0, 32'd1024, 32'hCAFEF00D, 1'b1);
    release_req();
    check("b2b_ready_low", 32'(n_low), 32'd11);
    check("b2b_mem0", 32'(mem[0]), 32'h0000F00D);
    check("b2b_mem1", 32'(mem[1]), 32'h0000CAFE);
    check("b2b_rdata_kept", rdata, 32'h12345678);

    // 5: reset in the third LOW cycle of a write
    @(posedge clk);
    #1;
    wr_en = 1'b1;
    address = 32'd1032;
    wdata = 32'h11112222;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_oe", 32'(sram_dq_oe), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_ready_req", 32'(ready), 32'd0);
    release_req();
    #1;
    check("abort_ready_idle", 32'(ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(32'hCAFEF00D);
    run_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    release_req();
    check("post_rst_ready_low", 32'(n_low), 32'd11);

    // 6: both enables -> write; rdata untouched
    run_access(1'b1, 1'b1, 32'd1036, 32'h0000A5A5, 1'b0);
    release_req();
    check("both_mem6", 32'(mem[6]), 32'h0000A5A5);
    check("both_mem7", 32'(mem[7]), 32'h00000000);
    check("both_we_lo", 32'(we_lo), 32'd4);
    check("both_rdata", rdata, 32'hCAFEF00D);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
